// File: rtl/grf_wb_ctrl.sv
// Register-file write-port initiator: merges the never-stalled W-stage result with a
// FIFO-buffered secondary source and exposes a pending-write lookup for hazard checks.
module grf_wb_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic        s_valid,
  input  logic [4:0]  s_a3,
  input  logic [31:0] s_wd,
  input  logic [31:0] s_pc,
  output logic        s_ready,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        pend1,
  output logic        pend2,
  output logic        RegWrite,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [31:0] PC
);

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       a3_q [DEPTH];
  logic [4:0]       a3_d [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      wd_d [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic        regwrite_q, regwrite_d;
  logic [4:0]  a3o_q, a3o_d;
  logic [31:0] wdo_q, wdo_d;
  logic [31:0] pco_q, pco_d;

  logic w_act, pop, push, full;
  logic [DEPTH-1:0] occ;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign s_ready = !full;
  assign w_act   = w_we && (w_a3 != '0);
  assign pop     = !w_act && (count_q != '0);
  assign push    = s_valid && !full && (s_a3 != '0);

  always_comb begin
    live_d     = live_q;
    a3_d       = a3_q;
    wd_d       = wd_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    regwrite_d = 1'b0;
    a3o_d      = a3o_q;
    wdo_d      = wdo_q;
    pco_d      = pco_q;

    if (w_act) begin
      regwrite_d = 1'b1;
      a3o_d      = w_a3;
      wdo_d      = w_wd;
      pco_d      = w_pc;
      // Younger W-stage value supersedes any queued write to the same register
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (a3_q[PTR_W'(i)] == w_a3) live_d[PTR_W'(i)] = 1'b0;
      end
    end else if (pop) begin
      regwrite_d = live_q[head_q];
      a3o_d      = a3_q[head_q];
      wdo_d      = wd_q[head_q];
      pco_d      = pc_q[head_q];
      head_d     = head_q + 1'b1;
    end

    // Applied after the kill so a same-cycle push to the killed register stays live
    if (push) begin
      live_d[tail_q] = 1'b1;
      a3_d[tail_q]   = s_a3;
      wd_d[tail_q]   = s_wd;
      pc_d[tail_q]   = s_pc;
      tail_d         = tail_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    occ   = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ[PTR_W'(i)] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
      if (occ[PTR_W'(i)] && live_q[PTR_W'(i)]) begin
        if (q_addr1 != '0 && a3_q[PTR_W'(i)] == q_addr1) pend1 = 1'b1;
        if (q_addr2 != '0 && a3_q[PTR_W'(i)] == q_addr2) pend2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      live_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      a3o_q      <= '0;
      wdo_q      <= '0;
      pco_q      <= '0;
    end else begin
      live_q     <= live_d;
      a3_q       <= a3_d;
      wd_q       <= wd_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      a3o_q      <= a3o_d;
      wdo_q      <= wdo_d;
      pco_q      <= pco_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign A3       = a3o_q;
  assign WD       = wdo_q;
  assign PC       = pco_q;

endmodule
